// File: rtl/pwm_demod.sv
// PWM-to-sample receiver: measures each PWM period and its high time, then
// recovers floor(high * 2^RESOLUTION / period) with a serial restoring divider.
module pwm_demod #(
  parameter int RESOLUTION = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  pwm_in,
  output logic [RESOLUTION-1:0] sample,
  output logic                  sample_valid,
  output logic [CNT_WIDTH-1:0]  period,
  output logic                  no_signal,
  output logic                  err_fast
);

  localparam int STAGES = RESOLUTION;
  localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_WIDTH:0]    rem;
    logic [CNT_WIDTH-1:0]  div;
    logic [RESOLUTION-1:0] quo;
  } div_t;

  state_t                state, state_nx;
  logic [1:0]            sync_q;
  logic                  s, s_d, rise;
  logic [CNT_WIDTH-1:0]  period_cnt, high_cnt;
  logic                  at_timeout;
  logic [STAGES:0]       vld_pipe;
  div_t                  dv;
  logic                  busy;
  logic                  flush, restart, count_en, capture, drop, timeout_hit;
  logic                  div_step, div_last, ge;
  logic [CNT_WIDTH:0]    rem_sh, rem_nx, div_ext;
  logic [RESOLUTION-1:0] quo_nx;

  assign s          = sync_q[1];
  assign rise       = s & ~s_d;
  assign at_timeout = (period_cnt == TO_CNT);
  // busy also covers the strobe cycle, so edges up to RESOLUTION+1 cycles apart collide
  assign busy       = |vld_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = ARM;
        ARM:     if (rise) state_nx = MEASURE;
        MEASURE: if (!rise && at_timeout) state_nx = ARM;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    flush       = 1'b0;
    restart     = 1'b0;
    count_en    = 1'b0;
    capture     = 1'b0;
    drop        = 1'b0;
    timeout_hit = 1'b0;
    if (!enable || state == IDLE) flush = 1'b1;
    else begin
      case (state)
        ARM: restart = rise;
        MEASURE: begin
          // an edge beats a simultaneous timeout
          if (rise) begin
            restart = 1'b1;
            capture = ~busy;
            drop    = busy;
          end else if (at_timeout) begin
            timeout_hit = 1'b1;
          end else begin
            count_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (flush) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (restart) begin
      period_cnt <= CNT_WIDTH'(1);
      high_cnt   <= CNT_WIDTH'(1);
    end else if (count_en) begin
      period_cnt <= period_cnt + CNT_WIDTH'(1);
      high_cnt   <= high_cnt + CNT_WIDTH'(s);
    end
  end

  // One restoring step per cycle, quotient MSB first; high < period keeps rem < div.
  always_comb begin
    div_ext  = {1'b0, dv.div};
    rem_sh   = dv.rem << 1;
    ge       = (rem_sh >= div_ext);
    rem_nx   = ge ? (rem_sh - div_ext) : rem_sh;
    quo_nx   = {dv.quo[RESOLUTION-2:0], ge};
    div_step = (|vld_pipe[STAGES-1:0]) & ~flush & ~timeout_hit;
    div_last = vld_pipe[STAGES-1] & ~flush & ~timeout_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dv       <= '0;
    end else begin
      vld_pipe <= (flush || timeout_hit) ? '0 : {vld_pipe[STAGES-1:0], capture};
      if (capture) begin
        dv <= '{rem: {1'b0, high_cnt}, div: period_cnt, quo: '0};
      end else if (div_step) begin
        dv.rem <= rem_nx;
        dv.quo <= quo_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      period       <= '0;
      no_signal    <= 1'b0;
      err_fast     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (flush) begin
        no_signal <= 1'b0;
        err_fast  <= 1'b0;
      end else begin
        if (drop)    err_fast <= 1'b1;
        if (capture) period   <= period_cnt;
        if (timeout_hit) begin
          sample       <= {RESOLUTION{s}};
          sample_valid <= 1'b1;
          no_signal    <= 1'b1;
        end else if (div_last) begin
          sample       <= quo_nx;
          sample_valid <= 1'b1;
          no_signal    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Randomised PWM stimulus; expected samples derived from rising-edge spacing
// and high-cycle counts of the generated waveform.
module tb_pwm_demod;
  localparam int RES = 8;
  localparam int CW  = 16;
  localparam int TO  = 1000;
  localparam int NEG = -1000000;

  logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, pwm_in = 1'b0;
  logic [RES-1:0] sample;
  logic           sample_valid;
  logic [CW-1:0]  period;
  logic           no_signal, err_fast;

  pwm_demod #(.RESOLUTION(RES), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
    .sample(sample), .sample_valid(sample_valid), .period(period),
    .no_signal(no_signal), .err_fast(err_fast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int smp;
    int per;
    bit ns;
  } ev_t;

  ev_t exp_q[$];
  bit  lv[$];
  int  last_period = 0;
  int  checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit due;
    due = (exp_q.size() > 0) && (exp_q[0].t == cyc);
    if (sample_valid || due) begin
      chk("valid", sample_valid, due);
      if (due) begin
        chk("sample", sample, exp_q[0].smp);
        chk("period", period, exp_q[0].per);
        chk("no_signal", no_signal, exp_q[0].ns);
        exp_q.delete(0);
      end
    end
  end

  task automatic add(input bit b, input int k);
    repeat (k) lv.push_back(b);
  endtask

  task automatic add_pwm(input int p, input int h);
    add(1'b1, h);
    add(1'b0, p - h);
  endtask

  task automatic new_seq();
    lv.delete();
    add(1'b0, 4);
  endtask

  // Level lv[i] is driven in cycle c0+i; its synchronised edge lands two cycles later.
  task automatic model(input int c0, input int rst_idx, output bit err_m, output bit ns_m);
    int n, r, last_cap;
    bit meas;
    n = lv.size();
    r = 0; meas = 0; last_cap = NEG; err_m = 0;
    for (int i = 0; i <= n - 3; i++) begin
      bit prev, rise;
      if (rst_idx >= 0 && i == rst_idx) begin
        meas = 0; last_cap = NEG; err_m = 0; last_period = 0;
        while (exp_q.size() > 0 && exp_q[$].t >= c0 + rst_idx) exp_q.delete(exp_q.size() - 1);
        continue;
      end
      prev = (i == 0) ? 1'b0 : lv[i-1];
      rise = lv[i] && !prev;
      if (rise) begin
        if (meas) begin
          int p, h;
          p = i - r;
          h = 0;
          for (int k = r; k < i; k++) h += int'(lv[k]);
          if (i - last_cap >= RES + 2) begin
            last_cap = i;
            last_period = p;
            exp_q.push_back('{t: c0 + i + RES + 3, smp: (h * (1 << RES)) / p, per: p, ns: 1'b0});
          end else begin
            err_m = 1;
          end
        end
        meas = 1;
        r = i;
      end else if (meas && (i - r == TO)) begin
        exp_q.push_back('{t: c0 + i + 3, smp: lv[i] ? (1 << RES) - 1 : 0, per: last_period, ns: 1'b1});
        meas = 0;
        last_cap = NEG;
      end
    end
    while (exp_q.size() > 0 && exp_q[$].t > c0 + n) exp_q.delete(exp_q.size() - 1);
    ns_m = 0;
    if (exp_q.size() > 0 && !(rst_idx >= 0 && exp_q[$].t < c0 + rst_idx)) ns_m = exp_q[$].ns;
  endtask

  task automatic run_seq(input int rst_idx);
    int n, c0;
    bit err_m, ns_m;
    n = lv.size();
    @(posedge clk); #1;
    c0 = cyc;
    model(c0, rst_idx, err_m, ns_m);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1;
      pwm_in = lv[i];
      if (rst_idx >= 0 && i == rst_idx) begin
        reset_n = 1'b0;
        #1;
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_period", period, 0);
        chk("rst_no_signal", no_signal, 0);
        chk("rst_err_fast", err_fast, 0);
      end
      if (rst_idx >= 0 && i == rst_idx + 1) reset_n = 1'b1;
      @(posedge clk); #1;
    end
    enable = 1'b0;
    pwm_in = 1'b0;
    @(negedge clk);
    chk("err_fast_end", err_fast, err_m);
    chk("no_signal_end", no_signal, ns_m);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_fast_clr", err_fast, 0);
    chk("pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int p, h;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_sample", sample, 0);
    chk("init_valid", sample_valid, 0);
    chk("init_period", period, 0);
    chk("init_no_signal", no_signal, 0);
    chk("init_err_fast", err_fast, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // period 256, high 64; a closing edge lets the last period be captured
    new_seq(); repeat (4) add_pwm(256, 64); add(1'b1, 1); add(1'b0, 20); run_seq(-1);

    new_seq(); repeat (3) add_pwm(100, 50); repeat (3) add_pwm(100, 1);
    add(1'b1, 1); add(1'b0, 20); run_seq(-1);

    new_seq();
    repeat (12) begin
      p = $urandom_range(10, 400); h = $urandom_range(1, p - 1); add_pwm(p, h);
    end
    add(1'b1, 1); add(1'b0, 20); run_seq(-1);

    // stuck low, then PWM resumes
    new_seq(); repeat (2) add_pwm(50, 20); add(1'b0, 1100);
    repeat (3) add_pwm(60, 15); add(1'b1, 1); add(1'b0, 20); run_seq(-1);

    // stuck high
    new_seq(); repeat (2) add_pwm(50, 20); add(1'b1, 1100); add(1'b0, 20); run_seq(-1);

    // periods too short for the divider
    new_seq(); repeat (10) add_pwm(6, 3); add(1'b0, 20); run_seq(-1);

    new_seq();
    repeat (30) begin
      p = $urandom_range(3, 30); h = $urandom_range(1, p - 1); add_pwm(p, h);
    end
    add(1'b1, 1); add(1'b0, 20); run_seq(-1);

    // reset three cycles after a capturing edge, then recovery
    new_seq(); repeat (2) add_pwm(40, 2); repeat (3) add_pwm(40, 2);
    add(1'b1, 1); add(1'b0, 20); run_seq(47);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
